// File: rtl/image_bram_arbiter.sv
// image_bram_arbiter: shares a single-port image BRAM between sequential UART frame writes and random-address pixel reads.
module image_bram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 38400,
  parameter int RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_restart,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic              wr_issue, last;
  // A restart in the issue cycle drops the pending byte instead of writing it.
  always_comb begin
    wr_issue     = pend_valid_q & ~frame_restart & ~rst;
    last         = wr_ptr_q == ADDR_W'(FRAME_PIXELS - 1);
    rd_grant     = rd_req & ~pend_valid_q & ~rst;
    pend_valid_d = wr_valid;
    pend_data_d  = wr_valid ? wr_data : pend_data_q;
    wr_ptr_d     = frame_restart ? '0 : wr_issue ? (last ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    state_d      = frame_restart ? IDLE : wr_issue ? (last ? FULL : FILL) : state_q;
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = rd_grant;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end
  assign bram_en    = wr_issue | rd_grant;
  assign bram_we    = wr_issue;
  assign bram_addr  = wr_issue ? wr_ptr_q : rd_grant ? rd_addr : '0;
  assign bram_din   = wr_issue ? pend_data_q : '0;
  assign frame_done = state_q == FULL;
  assign wr_ptr     = wr_ptr_q;
  assign rd_valid   = rd_pipe_q[RD_LAT-1];
  assign rd_data    = rd_valid ? bram_dout : '0;
endmodule
